// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Comparator response packed as {eq, lt, gt}.
  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b001;

  function automatic logic cmp_valid(input logic [2:0] code);
    return (code == CMP_EQ) || (code == CMP_LT) || (code == CMP_GT);
  endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Comparator/result bundle between the search controller (master) and its user/comparator (slave).
interface sar_search_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cmp_gt;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  modport master (
    input  start, cmp_eq, cmp_lt, cmp_gt,
    output probe, busy, done, result, found, err
  );

  modport slave (
    output start, cmp_eq, cmp_lt, cmp_gt,
    input  probe, busy, done, result, found, err
  );

endinterface

// File: rtl/sar_bit_ctr.sv
// Bit pointer (MSB-first) and probe settle counter for the SAR search controller.
module sar_bit_ctr #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  localparam int KW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic          settle_en,
  output logic [KW-1:0] k,
  output logic          last_bit,
  output logic          settle_done
);

  logic [KW-1:0] k_r;
  logic [CW-1:0] cnt_r;

  // Bit pointer reload/decrement and settle counting; counter restarts whenever DRIVE is left.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_r   <= KW'(0);
      cnt_r <= CW'(0);
    end else begin
      if (load) begin
        k_r <= KW'(WIDTH - 1);
      end else if (step) begin
        k_r <= k_r - KW'(1);
      end else begin
        k_r <= k_r;
      end
      if (settle_en && !settle_done) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= CW'(0);
      end
    end
  end

  // Status decode.
  always_comb begin
    k           = k_r;
    last_bit    = (k_r == KW'(0));
    settle_done = (cnt_r == CW'(SETTLE - 1));
  end

endmodule

// File: rtl/sar_search_ctrl.sv
// SAR search controller: binary-searches a hidden target through an external comparator.
// Optional build macro SAR_EARLY_EXIT_EN finishes the search as soon as the comparator reports equality.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sar_search_ctrl_if.master  bus
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] probe_r;
  logic [WIDTH-1:0] result_r;
  logic             found_r;
  logic             err_r;
  logic [2:0]       cmp_s;
  logic             code_ok_s;
  logic             early_s;
  logic [WIDTH-1:0] probe_upd_s;
  logic [WIDTH-1:0] probe_set_s;
  logic [KW-1:0]    k_s;
  logic             last_bit_s;
  logic             settle_done_s;
  logic             load_s;
  logic             step_s;
  logic             settle_en_s;

  assign cmp_s     = {bus.cmp_eq, bus.cmp_lt, bus.cmp_gt};
  assign code_ok_s = cmp_valid(cmp_s);
`ifdef SAR_EARLY_EXIT_EN
  assign early_s   = (cmp_s == CMP_EQ);
`else
  assign early_s   = 1'b0;
`endif

  assign load_s      = (state_r == ST_IDLE) && bus.start;
  assign step_s      = (state_r == ST_SAMPLE) && code_ok_s && !early_s && !last_bit_s;
  assign settle_en_s = (state_r == ST_DRIVE);

  sar_bit_ctr #(
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) u_bit_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load_s),
    .step        (step_s),
    .settle_en   (settle_en_s),
    .k           (k_s),
    .last_bit    (last_bit_s),
    .settle_done (settle_done_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = bus.start ? ST_DRIVE : ST_IDLE;
      ST_DRIVE:  state_nxt_s = settle_done_s ? ST_SAMPLE : ST_DRIVE;
      ST_SAMPLE: state_nxt_s = (!code_ok_s || early_s || last_bit_s) ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Trial update: resolve bit k from the comparator (eq keeps the bit), then arm bit k-1.
  always_comb begin
    probe_upd_s      = probe_r;
    probe_upd_s[k_s] = (cmp_s != CMP_LT);
    probe_set_s      = probe_upd_s;
    if (!last_bit_s) begin
      probe_set_s[k_s - KW'(1)] = 1'b1;
    end else begin
      probe_set_s = probe_upd_s;
    end
  end

  // Probe/result/status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      probe_r  <= '0;
      result_r <= '0;
      found_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            probe_r <= {1'b1, {(WIDTH-1){1'b0}}};
            found_r <= 1'b0;
            err_r   <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          if (!code_ok_s) begin
            err_r    <= 1'b1;
            found_r  <= 1'b0;
            result_r <= probe_r;
          end else if (early_s) begin
            result_r <= probe_r;
            found_r  <= 1'b1;
          end else if (last_bit_s) begin
            probe_r  <= probe_upd_s;
            result_r <= probe_upd_s;
            found_r  <= 1'b1;
          end else begin
            probe_r  <= probe_set_s;
          end
        end
        default: begin
          probe_r <= probe_r;
        end
      endcase
    end
  end

  // Output decode; busy/done derive directly from the state register.
  always_comb begin
    bus.probe  = probe_r;
    bus.result = result_r;
    bus.found  = found_r;
    bus.err    = err_r;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state_r)
      ST_DRIVE:  bus.busy = 1'b1;
      ST_SAMPLE: bus.busy = 1'b1;
      ST_DONE:   bus.done = 1'b1;
      default:   bus.busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed self-checking bench for sar_search_ctrl (WIDTH=4, SETTLE=1) with a behavioural comparator.
module tb_sar_search_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] target;
  logic       bad;
  int         tests;
  int         fails;

  sar_search_ctrl_if #(.WIDTH(4)) bus ();

  sar_search_ctrl #(
    .WIDTH  (4),
    .SETTLE (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Comparator: a = target, b = probe; 'bad' forces an illegal lt+gt code.
  always_comb begin
    bus.cmp_eq = 1'b0;
    bus.cmp_lt = 1'b0;
    bus.cmp_gt = 1'b0;
    if (bad) begin
      bus.cmp_lt = 1'b1;
      bus.cmp_gt = 1'b1;
    end else begin
      bus.cmp_eq = (target == bus.probe);
      bus.cmp_lt = (target <  bus.probe);
      bus.cmp_gt = (target >  bus.probe);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full search from IDLE: checks each probe, the done cycle and the held values afterwards.
  task automatic run_search(input logic [3:0] tgt, input int p0, input int p1,
                            input int p2, input int p3, input int res);
    target    = tgt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("probe0", 32'(bus.probe), 32'(p0));
    check("busy_run", 32'(bus.busy), 32'd1);
    check("done_run", 32'(bus.done), 32'd0);
    tick(); tick();
    check("probe1", 32'(bus.probe), 32'(p1));
    tick(); tick();
    check("probe2", 32'(bus.probe), 32'(p2));
    tick(); tick();
    check("probe3", 32'(bus.probe), 32'(p3));
    tick(); tick();
    check("done_pulse", 32'(bus.done), 32'd1);
    check("result", 32'(bus.result), 32'(res));
    check("found", 32'(bus.found), 32'd1);
    check("err_clear", 32'(bus.err), 32'd0);
    check("busy_done", 32'(bus.busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("probe_hold", 32'(bus.probe), 32'(res));
    check("result_hold", 32'(bus.result), 32'(res));
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bad       = 1'b0;
    target    = 4'd0;
    tick(); tick();
    check("rst_probe", 32'(bus.probe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_found", 32'(bus.found), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    tick();

    run_search(4'd11, 8, 12, 10, 11, 11);
    run_search(4'd0,  8, 4, 2, 1, 0);
    run_search(4'd15, 8, 12, 14, 15, 15);

`ifdef SAR_EARLY_EXIT_EN
    target    = 4'd8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("early_probe0", 32'(bus.probe), 32'd8);
    tick(); tick();
    check("early_done", 32'(bus.done), 32'd1);
    check("early_result", 32'(bus.result), 32'd8);
    check("early_found", 32'(bus.found), 32'd1);
    tick();
`else
    run_search(4'd8, 8, 12, 10, 9, 8);
`endif

    // Protocol error on the second SAMPLE, with start held high while busy and during DONE.
    target    = 4'd11;
    bus.start = 1'b1;
    tick();
    check("err_probe0", 32'(bus.probe), 32'd8);
    tick(); tick();
    check("start_ignored_busy", 32'(bus.probe), 32'd12);
    bus.start = 1'b0;
    tick();
    bad = 1'b1;
    tick();
    bad = 1'b0;
    check("err_done", 32'(bus.done), 32'd1);
    check("err_flag", 32'(bus.err), 32'd1);
    check("err_found", 32'(bus.found), 32'd0);
    check("err_result", 32'(bus.result), 32'd12);
    check("err_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_ignored_done", 32'(bus.busy), 32'd0);
    check("err_probe_hold", 32'(bus.probe), 32'd12);
    tick();
    check("err_still_idle", 32'(bus.busy), 32'd0);

    // Reset mid-search, then a fresh search.
    target    = 4'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    check("pre_rst_probe", 32'(bus.probe), 32'd4);
    rst_n = 1'b0;
    tick();
    check("mid_rst_probe", 32'(bus.probe), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_found", 32'(bus.found), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    tick();
    run_search(4'd6, 8, 4, 6, 7, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
